fifo_wr_arbiter: RTL

//   Round-robin write arbiter sharing one synchronous FIFO write port among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: merges NUM_REQ producers onto one registered FIFO write port,
// throttling on full/almostfull and tracking acks and overflow.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [ID_W-1:0]               gnt_id,
    output logic [CNT_W-1:0]              ack_cnt,
    output logic                          ovf_err
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] rr_ptr_nxt;
    logic            gnt_valid;
    logic            space_ok;
    int              idx;

    // The write already on the port will consume the last free slot, so almostfull
    // plus an in-flight write is treated the same as full.
    always_comb begin
        space_ok  = !fifo_full && !(fifo_almostfull && fifo_wr_en);
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        req_ready = '0;
        if (!rst && en && space_ok) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!gnt_valid && req_valid[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = ID_W'(idx);
                end
            end
        end
        req_ready[gnt_idx] = gnt_valid;
    end

    always_comb begin
        if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            gnt_id       <= '0;
            ack_cnt      <= '0;
            ovf_err      <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            fifo_wr_en <= gnt_valid;
            if (gnt_valid) begin
                fifo_data_in <= req_data[gnt_idx*FIFO_WIDTH +: FIFO_WIDTH];
                gnt_id       <= gnt_idx;
                rr_ptr       <= rr_ptr_nxt;
            end
            if (fifo_wr_ack) begin
                ack_cnt <= ack_cnt + CNT_W'(1);
            end
            if (fifo_overflow) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule
